// File: rtl/ocram_pkg.sv
// Shared types and constants for the nios2 on-chip RAM slave.
// Optional parity storage is enabled with the OCRAM_PARITY_EN macro.
package ocram_pkg;

    typedef enum logic {
        INIT_CLEAR,
        READY
    } state_t;

    // Lane count for the default 32-bit build; parametrised modules derive their own.
    localparam int DEFAULT_DATA_W = 32;
    localparam int BYTES          = DEFAULT_DATA_W / 8;

    // Deepest read pipeline supported (bank register plus one output register).
    localparam int MAX_LATENCY = 2;

`ifdef OCRAM_PARITY_EN
    // Even parity: the stored bit makes the 9-bit lane have an even number of ones.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

endpackage

// File: rtl/nios2_ocram_pipe_if.sv
// Avalon-MM slave bundle for nios2_ocram_pipe.
// readerror exists only when OCRAM_PARITY_EN is defined.
interface nios2_ocram_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 17
);
    logic                  reset_req;
    logic                  clken;
    logic                  chipselect;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W/8-1:0]   byteenable;
    logic                  write;
    logic                  read;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;
    logic                  waitrequest;
    logic                  init_done;
`ifdef OCRAM_PARITY_EN
    logic                  readerror;

    modport master (
        output reset_req, clken, chipselect, address, byteenable, write, read, writedata,
        input  readdata, readdatavalid, waitrequest, init_done, readerror
    );
    modport slave (
        input  reset_req, clken, chipselect, address, byteenable, write, read, writedata,
        output readdata, readdatavalid, waitrequest, init_done, readerror
    );
`else
    modport master (
        output reset_req, clken, chipselect, address, byteenable, write, read, writedata,
        input  readdata, readdatavalid, waitrequest, init_done
    );
    modport slave (
        input  reset_req, clken, chipselect, address, byteenable, write, read, writedata,
        output readdata, readdatavalid, waitrequest, init_done
    );
`endif
endinterface

// File: rtl/ocram_bank.sv
// Single-port lane-enabled RAM with registered read. Each lane is LANE_W bits
// wide (8, or 9 when the top stores a parity bit per byte).
module ocram_bank #(
    parameter int DEPTH  = 16,
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic                         we,
    input  logic [LANES-1:0]             be,
    input  logic [AW-1:0]                addr,
    input  logic [LANES-1:0][LANE_W-1:0] wdata,
    output logic [LANES-1:0][LANE_W-1:0] rdata
);

    logic [LANES-1:0][LANE_W-1:0] mem [DEPTH];

    // Lane-masked write, otherwise a registered read of the addressed word
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < LANES; i++) begin
                    if (be[i]) begin
                        mem[addr][i] <= wdata[i];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/nios2_ocram_pipe.sv
// Avalon-MM on-chip RAM slave: post-reset clear sequence, byte-enabled writes,
// 1- or 2-cycle pipelined reads with readdatavalid, clken/reset_req stall.
// Define OCRAM_PARITY_EN to store per-byte parity and add readerror.
module nios2_ocram_pipe
    import ocram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 131072,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int RD_LATENCY     = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic               clk,
    input logic               reset,
    nios2_ocram_pipe_if.slave bus
);

    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef OCRAM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t                       state;
    logic [IDX_W-1:0]             clr_count;
    logic                         init_done_reg;
    logic                         stall;
    logic                         wait_int;
    logic [ADDR_W-1:0]            addr;
    logic                         in_range;
    logic                         wr_acc;
    logic                         rd_acc;
    logic                         bank_en;
    logic                         bank_we;
    logic [LANES-1:0]             bank_be;
    logic [IDX_W-1:0]             bank_addr;
    logic [LANES-1:0][LANE_W-1:0] bank_wdata;
    logic [LANES-1:0][LANE_W-1:0] wr_lanes;
    logic [LANES-1:0][LANE_W-1:0] rd_lanes;
    logic [DATA_W-1:0]            rd_bytes;
    logic [DATA_W-1:0]            s1_data;
    logic [DATA_W-1:0]            out_data;
    logic                         p1_valid_reg;
    logic                         p1_oor_reg;
    logic                         out_valid;

    assign stall    = ~bus.clken | bus.reset_req;
    assign wait_int = ~init_done_reg | stall;
    assign addr     = bus.address;
    assign in_range = 33'(addr) < 33'(DEPTH);
    // Write wins over a simultaneous read; the read is simply not accepted.
    assign wr_acc   = bus.chipselect & bus.write & ~wait_int;
    assign rd_acc   = bus.chipselect & bus.read & ~bus.write & ~wait_int;

    assign bus.waitrequest = wait_int;
    assign bus.init_done   = init_done_reg;

`ifdef OCRAM_PARITY_EN
    logic [LANES-1:0] lane_bad;
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef OCRAM_PARITY_EN
        assign wr_lanes[gi] = {even_parity(bus.writedata[8*gi +: 8]), bus.writedata[8*gi +: 8]};
        assign lane_bad[gi] = rd_lanes[gi][8] ^ even_parity(rd_lanes[gi][7:0]);
`else
        assign wr_lanes[gi] = bus.writedata[8*gi +: 8];
`endif
        assign rd_bytes[8*gi +: 8] = rd_lanes[gi][7:0];
    end

    // Clear sequencer: one zero word per enabled cycle, then READY until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if (CLEAR_ON_RESET) begin
                state <= INIT_CLEAR;
            end else begin
                state <= READY;
            end
            clr_count     <= '0;
            init_done_reg <= 1'b0;
        end else if (!stall) begin
            case (state)
                INIT_CLEAR: begin
                    if (clr_count == LAST_IDX) begin
                        state         <= READY;
                        init_done_reg <= 1'b1;
                    end else begin
                        clr_count <= clr_count + 1'b1;
                    end
                end
                default: init_done_reg <= 1'b1;
            endcase
        end
    end

    // Bank port steering: clear writes, accepted in-range writes, accepted reads
    always_comb begin
        bank_en    = 1'b0;
        bank_we    = 1'b0;
        bank_be    = bus.byteenable;
        bank_addr  = addr[IDX_W-1:0];
        bank_wdata = wr_lanes;
        if (state == INIT_CLEAR) begin
            bank_en    = ~stall;
            bank_we    = 1'b1;
            bank_be    = '1;
            bank_addr  = clr_count;
            bank_wdata = '0;
        end else if (wr_acc) begin
            bank_en = in_range;
            bank_we = 1'b1;
        end else if (rd_acc) begin
            bank_en = 1'b1;
        end
    end

    ocram_bank #(
        .DEPTH  (DEPTH),
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .AW     (IDX_W)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en),
        .we    (bank_we),
        .be    (bank_be),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .rdata (rd_lanes)
    );

    // First read stage tracks validity and out-of-range alongside the bank register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_valid_reg <= 1'b0;
            p1_oor_reg   <= 1'b0;
        end else if (!stall) begin
            p1_valid_reg <= rd_acc;
            p1_oor_reg   <= ~in_range;
        end
    end

    assign s1_data = (p1_valid_reg && !p1_oor_reg) ? rd_bytes : '0;

`ifdef OCRAM_PARITY_EN
    logic [LANES-1:0] p1_be_reg;
    logic             s1_err;
    logic             out_err;

    // Lanes requested by the read decide which parity failures count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_be_reg <= '0;
        end else if (!stall) begin
            p1_be_reg <= bus.byteenable;
        end
    end

    assign s1_err        = p1_valid_reg & ~p1_oor_reg & |(lane_bad & p1_be_reg);
    assign bus.readerror = out_err & ~stall;
`endif

    if (RD_LATENCY >= MAX_LATENCY) begin : g_lat2
        logic              p2_valid_reg;
        logic [DATA_W-1:0] p2_data_reg;

        // Extra output register stage
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                p2_valid_reg <= 1'b0;
                p2_data_reg  <= '0;
            end else if (!stall) begin
                p2_valid_reg <= p1_valid_reg;
                p2_data_reg  <= s1_data;
            end
        end

        assign out_valid = p2_valid_reg;
        assign out_data  = p2_data_reg;

`ifdef OCRAM_PARITY_EN
        logic p2_err_reg;

        // Parity flag travels with the data through the output stage
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                p2_err_reg <= 1'b0;
            end else if (!stall) begin
                p2_err_reg <= s1_err;
            end
        end

        assign out_err = p2_err_reg;
`endif
    end else begin : g_lat1
        assign out_valid = p1_valid_reg;
        assign out_data  = s1_data;
`ifdef OCRAM_PARITY_EN
        assign out_err   = s1_err;
`endif
    end

    // A held result is only presented once the stall lifts
    assign bus.readdatavalid = out_valid & ~stall;
    assign bus.readdata      = out_data;

endmodule

// File: tb/tb_nios2_ocram_pipe.sv
// Self-checking bench for nios2_ocram_pipe (DEPTH=16, RD_LATENCY=2, 5-bit address
// so out-of-range words 16..19 can be reached). Build with OCRAM_PARITY_EN to
// include the parity scenario.
module tb_nios2_ocram_pipe;

    localparam int DEPTH = 16;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    nios2_ocram_pipe_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    nios2_ocram_pipe #(
        .DATA_W         (32),
        .DEPTH          (DEPTH),
        .ADDR_W         (5),
        .RD_LATENCY     (LAT),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: word array, per-lane corruption marks, and a queue of
    // outstanding reads aged in enabled clock edges.
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          age;
    } rd_t;

    rd_t         q[$];
    logic [31:0] mem_m   [DEPTH];
    logic [3:0]  corrupt [DEPTH];
    int          clear_left;
    bit          in_reset;

    logic        exp_rdv, exp_wait, exp_done, exp_err;
    logic [31:0] exp_rd;
    logic        got_rdv, got_wait, got_done, got_err;
    logic [31:0] got_rd;

    int n_cmp  = 0;
    int n_fail = 0;

    // Drive one cycle, sample at the falling edge, predict, then advance the model.
    task automatic drive_cycle(input logic cs, input logic rd, input logic wr,
                               input logic [4:0] a, input logic [3:0] be,
                               input logic [31:0] wd, input logic ce, input logic rr);
        bit stalled;
        bus.chipselect = cs;
        bus.read       = rd;
        bus.write      = wr;
        bus.address    = a;
        bus.byteenable = be;
        bus.writedata  = wd;
        bus.clken      = ce;
        bus.reset_req  = rr;
        @(negedge clk);
        stalled  = !ce || rr;
        exp_wait = in_reset || clear_left != 0 || stalled;
        exp_done = !in_reset && clear_left == 0;
        exp_rdv  = !in_reset && !stalled && q.size() > 0 && q[0].age == LAT;
        exp_rd   = exp_rdv ? q[0].data : 32'h0;
        exp_err  = exp_rdv ? q[0].err : 1'b0;
        got_rdv  = bus.readdatavalid;
        got_rd   = bus.readdata;
        got_wait = bus.waitrequest;
        got_done = bus.init_done;
`ifdef OCRAM_PARITY_EN
        got_err  = bus.readerror;
`else
        got_err  = 1'b0;
`endif
        if (!in_reset && !stalled) begin
            if (exp_rdv) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (clear_left != 0) begin
                clear_left--;
            end else if (cs && wr) begin
                if (a < DEPTH) begin
                    for (int l = 0; l < 4; l++) begin
                        if (be[l]) begin
                            mem_m[a[3:0]][8*l +: 8] = wd[8*l +: 8];
                            corrupt[a[3:0]][l]      = 1'b0;
                        end
                    end
                end
            end else if (cs && rd) begin
                q.push_back('{data: (a < DEPTH) ? mem_m[a[3:0]] : 32'h0,
                              err:  (a < DEPTH) ? |(corrupt[a[3:0]] & be) : 1'b0,
                              age:  1});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        reset    = 1'b1;
        in_reset = 1'b1;
        q.delete();
        clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]   = 32'h0;
            corrupt[i] = 4'h0;
        end
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 5'd0, 4'h0, 32'h0, 1, 0);
        reset    = 1'b0;
        in_reset = 1'b0;
    endtask

    task automatic test_reset();
        int clr_cycles = 0;
        apply_reset(2);
        if (got_wait !== 1'b1 || got_done !== 1'b0 || got_rdv !== 1'b0 || got_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: wait=%b done=%b rdv=%b data=%h, expected 1 0 0 00000000",
                     got_wait, got_done, got_rdv, got_rd);
        end
        n_cmp++;
        for (int k = 0; k < 40; k++) begin
            drive_cycle(0, 0, 0, 5'd0, 4'h0, 32'h0, 1, 0);
            if (got_done === 1'b1) break;
            if (got_wait === 1'b1) clr_cycles++;
        end
        if (clr_cycles != DEPTH || got_done !== 1'b1 || got_wait !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_length: wait cycles=%0d done=%b wait=%b, expected %0d 1 0",
                     clr_cycles, got_done, got_wait, DEPTH);
        end
        n_cmp++;
    endtask

    task automatic test_clear_contents();
        int seen = 0;
        for (int k = 0; k < DEPTH + 4; k++) begin
            drive_cycle(k < DEPTH, k < DEPTH, 0, 5'(k), 4'hF, 32'h0, 1, 0);
            if (got_rdv !== exp_rdv || (got_rdv === 1'b1 && got_rd !== 32'h0)) begin
                n_fail++;
                $display("FAIL clear_read cyc%0d: rdv=%b data=%h, expected rdv=%b data=00000000",
                         k, got_rdv, got_rd, exp_rdv);
            end
            n_cmp++;
            if (got_rdv === 1'b1) seen++;
        end
        if (seen != DEPTH) begin
            n_fail++;
            $display("FAIL clear_read_count: %0d results, expected %0d", seen, DEPTH);
        end
        n_cmp++;
    endtask

    task automatic test_byte_write();
        int seen = 0;
        drive_cycle(1, 0, 1, 5'd5, 4'b1111, 32'hDEADBEEF, 1, 0);
        drive_cycle(1, 0, 1, 5'd5, 4'b0101, 32'h11223344, 1, 0);
        drive_cycle(1, 1, 0, 5'd5, 4'b1111, 32'h0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            drive_cycle(0, 0, 0, 5'd0, 4'h0, 32'h0, 1, 0);
            if (got_rdv === 1'b1) begin
                seen++;
                if (got_rd !== 32'hDE22BE44) begin
                    n_fail++;
                    $display("FAIL byte_write: data=%h, expected de22be44", got_rd);
                end
                n_cmp++;
            end
        end
        if (seen != 1) begin
            n_fail++;
            $display("FAIL byte_write_count: %0d results, expected 1", seen);
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        for (int a = 1; a <= 3; a++) drive_cycle(1, 0, 1, 5'(a), 4'hF, $urandom, 1, 0);
        for (int k = 0; k < 7; k++) begin
            drive_cycle(k < 3, k < 3, 0, 5'(k + 1), 4'hF, 32'h0, 1, 0);
            if (got_rdv !== (k >= 2 && k <= 4)) begin
                n_fail++;
                $display("FAIL b2b_valid cyc+%0d: rdv=%b, expected %b", k, got_rdv, (k >= 2 && k <= 4));
            end
            n_cmp++;
            if (k >= 2 && k <= 4) begin
                if (got_rd !== mem_m[k - 1]) begin
                    n_fail++;
                    $display("FAIL b2b_data cyc+%0d: data=%h, expected %h", k, got_rd, mem_m[k - 1]);
                end
                n_cmp++;
            end
        end
    endtask

    task automatic test_raw();
        for (int t = 0; t < 4; t++) begin
            logic [4:0]  a  = 5'($urandom_range(0, DEPTH - 1));
            logic [31:0] wd = $urandom;
            int          seen = 0;
            drive_cycle(1, 0, 1, a, 4'hF, wd, 1, 0);
            drive_cycle(1, 1, 0, a, 4'hF, 32'h0, 1, 0);
            for (int k = 0; k < 3; k++) begin
                drive_cycle(0, 0, 0, 5'd0, 4'h0, 32'h0, 1, 0);
                if (got_rdv === 1'b1) begin
                    seen++;
                    if (got_rd !== wd) begin
                        n_fail++;
                        $display("FAIL raw addr%0d: data=%h, expected %h", a, got_rd, wd);
                    end
                    n_cmp++;
                end
            end
            if (seen != 1) begin
                n_fail++;
                $display("FAIL raw_count addr%0d: %0d results, expected 1", a, seen);
            end
            n_cmp++;
        end
    endtask

    task automatic test_stall();
        logic [4:0] a = 5'($urandom_range(0, DEPTH - 1));
        drive_cycle(1, 1, 0, a, 4'hF, 32'h0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1, 1, 0, 5'd0, 4'hF, 32'h0, 0, 0);
            if (got_rdv !== 1'b0 || got_wait !== 1'b1) begin
                n_fail++;
                $display("FAIL stall cyc%0d: rdv=%b wait=%b, expected 0 1", k, got_rdv, got_wait);
            end
            n_cmp++;
        end
        for (int k = 0; k < 3; k++) begin
            drive_cycle(0, 0, 0, 5'd0, 4'h0, 32'h0, 1, 0);
            if (got_rdv !== (k == 1) || (k == 1 && got_rd !== mem_m[a[3:0]])) begin
                n_fail++;
                $display("FAIL stall_release cyc%0d: rdv=%b data=%h, expected rdv=%b data=%h",
                         k, got_rdv, got_rd, (k == 1), mem_m[a[3:0]]);
            end
            n_cmp++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic       cs = ($urandom_range(0, 3) != 0);
            logic       rd = $urandom_range(0, 1);
            logic       wr = ($urandom_range(0, 2) == 0);
            logic       ce = ($urandom_range(0, 9) != 0);
            logic       rr = ($urandom_range(0, 19) == 0);
            logic [4:0] a  = 5'($urandom_range(0, DEPTH + 3));
            drive_cycle(cs, rd, wr, a, 4'($urandom), $urandom, ce, rr);
            if (got_wait !== exp_wait || got_rdv !== exp_rdv ||
                (exp_rdv && (got_rd !== exp_rd || got_err !== exp_err))) begin
                n_fail++;
                $display("FAIL random cyc%0d: wait=%b rdv=%b data=%h err=%b, expected wait=%b rdv=%b data=%h err=%b",
                         k, got_wait, got_rdv, got_rd, got_err, exp_wait, exp_rdv, exp_rd, exp_err);
            end
            n_cmp++;
        end
        for (int k = 0; k < 4; k++) drive_cycle(0, 0, 0, 5'd0, 4'h0, 32'h0, 1, 0);
    endtask

    task automatic test_reset_mid_clear();
        int clr_cycles = 0;
        int stray = 0;
        apply_reset(1);
        for (int k = 0; k < 7; k++) drive_cycle(0, 0, 0, 5'd0, 4'h0, 32'h0, 1, 0);
        apply_reset(1);
        for (int k = 0; k < 80; k++) begin
            logic ce = ($urandom_range(0, 3) != 0);
            drive_cycle(0, 0, 0, 5'd0, 4'h0, 32'h0, ce, 0);
            if (got_wait !== exp_wait || got_done !== exp_done) begin
                n_fail++;
                $display("FAIL restart_clear cyc%0d: wait=%b done=%b, expected %b %b",
                         k, got_wait, got_done, exp_wait, exp_done);
            end
            n_cmp++;
            if (got_done === 1'b1) break;
            if (ce) clr_cycles++;
        end
        if (clr_cycles != DEPTH || got_done !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear_length: enabled clear cycles=%0d done=%b, expected %0d 1",
                     clr_cycles, got_done, DEPTH);
        end
        n_cmp++;
        drive_cycle(1, 1, 0, 5'd3, 4'hF, 32'h0, 1, 0);
        apply_reset(1);
        for (int k = 0; k < 20; k++) begin
            drive_cycle(0, 0, 0, 5'd0, 4'h0, 32'h0, 1, 0);
            if (got_rdv === 1'b1) stray++;
        end
        if (stray != 0 || got_done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_read: stray results=%0d done=%b, expected 0 1", stray, got_done);
        end
        n_cmp++;
    endtask

`ifdef OCRAM_PARITY_EN
    task automatic test_parity();
        int seen = 0;
        drive_cycle(1, 0, 1, 5'd8, 4'hF, $urandom, 1, 0);
        drive_cycle(1, 0, 1, 5'd9, 4'hF, $urandom, 1, 0);
        dut.u_bank.mem[9][2][3] = ~dut.u_bank.mem[9][2][3];
        mem_m[9][19]  = ~mem_m[9][19];
        corrupt[9][2] = 1'b1;
        drive_cycle(1, 1, 0, 5'd9, 4'hF, 32'h0, 1, 0);
        drive_cycle(1, 1, 0, 5'd8, 4'hF, 32'h0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            drive_cycle(0, 0, 0, 5'd0, 4'h0, 32'h0, 1, 0);
            if (got_rdv === 1'b1) begin
                if (got_err !== (seen == 0) || got_rd !== exp_rd) begin
                    n_fail++;
                    $display("FAIL parity result%0d: err=%b data=%h, expected err=%b data=%h",
                             seen, got_err, got_rd, (seen == 0), exp_rd);
                end
                n_cmp++;
                seen++;
            end else begin
                if (got_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL parity_idle: err=%b without readdatavalid, expected 0", got_err);
                end
                n_cmp++;
            end
        end
        if (seen != 2) begin
            n_fail++;
            $display("FAIL parity_count: %0d results, expected 2", seen);
        end
        n_cmp++;
    endtask
`endif

    initial begin
        reset          = 1'b1;
        in_reset       = 1'b1;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.byteenable = '0;
        bus.writedata  = '0;
        bus.clken      = 1'b1;
        bus.reset_req  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_clear_contents();
        test_byte_write();
        test_back_to_back();
        test_raw();
        test_stall();
        test_random();
        test_reset_mid_clear();
`ifdef OCRAM_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nios2_ocram_pipe.md
Name: nios2_ocram_pipe

Overview:
Parametrised on-chip RAM Avalon-MM slave, next generation of the single-port onchip RAM in the nios2 system. It adds generic data width and depth, and a selectable 1- or 2-cycle pipelined read with readdatavalid. It also has waitrequest back-pressure and a hardware clear sequence that zeroes the array after reset. It sits on the Nios II data/instruction interconnect as a memory slave.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
DEPTH, 131072, number of words; need not be a power of two
ADDR_W, $clog2(DEPTH), word address width
RD_LATENCY, 1, read latency in cycles from accepted read to readdatavalid; legal values are 1 and 2
CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = go straight to READY with contents undefined

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
reset_req  in  1  reset request; while high, behaves as clken=0
clken  in  1  clock enable; low freezes the pipeline and all state
chipselect  in  1  slave select
address  in  ADDR_W  word address
byteenable  in  DATA_W/8  byte lane enables for writes
write  in  1  write strobe
read  in  1  read strobe
writedata  in  DATA_W  write data
readdata  out  DATA_W  read data; valid only when readdatavalid=1
readdatavalid  out  1  one-cycle pulse per accepted read
waitrequest  out  1  high means the slave cannot accept a command this cycle
init_done  out  1  high once the clear sequence has finished

Behaviour:
- Reset values (async): state=INIT_CLEAR if CLEAR_ON_RESET else READY; clear counter=0; readdata=0; readdatavalid=0; waitrequest=1; init_done=0; pipeline valid bits=0.
- States:
  - INIT_CLEAR: writes 0 to word[counter] with all bytes enabled, one word per enabled cycle. Counter increments; when counter==DEPTH-1 the word is written and the state moves to READY. waitrequest=1 throughout.
  - READY: init_done=1 and waitrequest=~(clken & ~reset_req). The state persists until reset.
- Accept rule: a command is accepted when chipselect & (read|write) & ~waitrequest.
- Write and read on the same cycle: write has priority and the read is dropped; no readdatavalid is generated for it.
- Write: bytes with byteenable[i]=1 are updated on the accepting edge; all other bytes keep their value.
- Read:
  - RD_LATENCY=1: readdata and readdatavalid are registered one edge after acceptance.
  - RD_LATENCY=2: an extra output register stage is added.
  - Back-to-back reads give one result per cycle.
  - A read accepted on the cycle after a write to the same address returns the newly written data.
- clken=0 or reset_req=1:
  - No array access; pipeline registers and clear counter hold.
  - readdatavalid is forced to 0 while stalled; pending results are kept and emitted after the stall ends.
- Out-of-range address (address>=DEPTH): writes are ignored; reads return 0 with a normal readdatavalid.
- Reset asserted mid-clear or mid-read: the clear restarts from 0 and in-flight reads are discarded with no readdatavalid.
- Commands presented during INIT_CLEAR are not accepted; the master must hold them until waitrequest falls.

Optional Feature:
OCRAM_PARITY_EN
- Defined:
  - Each byte lane stores an extra even-parity bit, written alongside the data and also by the clear sequence.
  - Read data is checked and a new output port readerror (1 bit) is added. readerror is aligned with readdatavalid, high if any enabled lane's parity mismatches, and resets to 0.
  - A parity failure does not change readdata.
- Not defined: no parity storage and no readerror port.

Decomposition:
- Package ocram_pkg:
  - state enum {INIT_CLEAR, READY}
  - localparams BYTES=DATA_W/8 and MAX_LATENCY=2
  - parity helper function (compiled only under OCRAM_PARITY_EN)
- Sub-module ocram_bank: inferred single-port byte-enabled array (DEPTH x DATA_W, plus BYTES parity bits when enabled) with a synchronous read. The top level holds the FSM, accept logic, latency pipeline and out-of-range handling.

Test Plan:
- Reset release, DEPTH=16, CLEAR_ON_RESET=1 -> waitrequest=1 for exactly 16 enabled cycles, then init_done=1; reads of all 16 words return 0x00000000.
- Write 0xDEADBEEF to addr 5 with be=4'b1111, then write 0x11223344 with be=4'b0101 -> read addr 5 returns 0xDE22BE44.
- Back-to-back reads of addrs 1,2,3 with RD_LATENCY=2 -> readdatavalid high on cycles +2,+3,+4, with data in order.
- clken=0 for 3 cycles while a read is pending -> no readdatavalid during the stall; data emitted 1 cycle after clken returns high; waitrequest=1 during the stall.
- Reset pulsed at counter=7 during clear -> counter restarts at 0; a full 16-cycle clear follows; init_done=0 until it completes.
- With OCRAM_PARITY_EN, force a flipped bit in byte 2 of addr 9 via backdoor, then read addr 9 -> readerror=1 together with readdatavalid; a read of clean addr 8 gives readerror=0.
